// File: rtl/hit_response.sv
`default_nettype none
// ============================================================================
// Module   : hit_response
// Brief    : Per-frame touch resolver: issues ball velocity loads, enforces a
//            re-hit cooldown and a per-side touch limit with foul reporting.
// Revision : 1.0 - initial release
// ============================================================================
module hit_response #(
   parameter int COOLDOWN_FRAMES = 20,
   parameter int BUMP_VY         = 9,
   parameter int SPIKE_VX        = 12,
   parameter int SPIKE_VY        = 4,
   parameter int MAX_VX          = 10,
   parameter int MAX_TOUCHES     = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               inrange,
   input  logic               spike,
   input  logic               facing_right,
   input  logic signed [10:0] ball_pos_x,
   input  logic signed [10:0] chara_pos_x,
   input  logic               touch_clr,
   output logic               set_vel,
   output logic signed [10:0] new_vx,
   output logic signed [10:0] new_vy,
   output logic [1:0]         touches,
   output logic               foul,
   output logic               busy
);

   localparam logic [1:0] c_ST_IDLE     = 2'd0;
   localparam logic [1:0] c_ST_HIT      = 2'd1;
   localparam logic [1:0] c_ST_COOLDOWN = 2'd2;

   localparam int c_CNT_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

   localparam logic [1:0]         c_MAX_TOUCHES = 2'(MAX_TOUCHES);
   localparam logic signed [11:0] c_MAX_VX      = 12'(MAX_VX);
   localparam logic signed [11:0] c_MIN_VX      = 12'(-MAX_VX);
   localparam logic signed [10:0] c_SPIKE_VX_P  = 11'(SPIKE_VX);
   localparam logic signed [10:0] c_SPIKE_VX_N  = 11'(-SPIKE_VX);
   localparam logic signed [10:0] c_SPIKE_VY    = 11'(SPIKE_VY);
   localparam logic signed [10:0] c_BUMP_VY     = 11'(-BUMP_VY);

   logic [1:0]          r_state;
   logic [1:0]          w_next;
   logic [c_CNT_W-1:0]  r_cnt;

   logic                w_start;
   logic                w_allow;
   logic [1:0]          w_touch_base;
   logic signed [11:0]  w_dx;
   logic signed [11:0]  w_shift;
   logic signed [11:0]  w_bump_vx;

   logic                w_set_vel;
   logic                w_foul;
   logic                w_busy;
   logic [1:0]          w_touches;
   logic signed [10:0]  w_vx;
   logic signed [10:0]  w_vy;

   // The decision is taken in the IDLE cycle so set_vel lands registered in HIT.
   assign w_start      = (r_state == c_ST_IDLE) && frame_tick && inrange;
   assign w_touch_base = touch_clr ? 2'd0 : touches;
   assign w_allow      = (w_touch_base < c_MAX_TOUCHES);
   assign w_dx         = {ball_pos_x[10], ball_pos_x} - {chara_pos_x[10], chara_pos_x};
   assign w_shift      = w_dx >>> 2;

   always_comb begin
      w_bump_vx = w_shift;
      if (w_shift > c_MAX_VX) begin
         w_bump_vx = c_MAX_VX;
      end else if (w_shift < c_MIN_VX) begin
         w_bump_vx = c_MIN_VX;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE:     if (w_start) w_next = c_ST_HIT;
         c_ST_HIT:      w_next = c_ST_COOLDOWN;
         c_ST_COOLDOWN: if ((r_cnt == '0) && !inrange) w_next = c_ST_IDLE;
         default:       w_next = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_set_vel = w_start && w_allow;
      w_foul    = w_start && !w_allow;
      w_busy    = (w_next == c_ST_COOLDOWN);
      w_touches = w_touch_base;
      w_vx      = new_vx;
      w_vy      = new_vy;
      if (w_set_vel) begin
         w_touches = w_touch_base + 2'd1;
         if (spike) begin
            w_vx = facing_right ? c_SPIKE_VX_P : c_SPIKE_VX_N;
            w_vy = c_SPIKE_VY;
         end else begin
            w_vx = w_bump_vx[10:0];
            w_vy = c_BUMP_VY;
         end
      end
   end

   // Counter saturates at zero while the character lingers in the hit box.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_state == c_ST_HIT) begin
         r_cnt <= c_CNT_W'(COOLDOWN_FRAMES);
      end else if ((r_state == c_ST_COOLDOWN) && frame_tick && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         set_vel <= 1'b0;
         foul    <= 1'b0;
         busy    <= 1'b0;
         touches <= 2'd0;
         new_vx  <= '0;
         new_vy  <= '0;
      end else begin
         set_vel <= w_set_vel;
         foul    <= w_foul;
         busy    <= w_busy;
         touches <= w_touches;
         new_vx  <= w_vx;
         new_vy  <= w_vy;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hit_response.sv
`default_nettype none
// ============================================================================
// Module   : tb_hit_response
// Brief    : Randomized self-checking bench for hit_response against a
//            frame-level behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hit_response;

   logic               clk = 1'b0;
   logic               rst;
   logic               frame_tick;
   logic               inrange;
   logic               spike;
   logic               facing_right;
   logic signed [10:0] ball_pos_x;
   logic signed [10:0] chara_pos_x;
   logic               touch_clr;
   logic               set_vel;
   logic signed [10:0] new_vx;
   logic signed [10:0] new_vy;
   logic [1:0]         touches;
   logic               foul;
   logic               busy;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit m_ready, m_in_hit, m_cooling;
   int m_left, m_touches, m_vx, m_vy;
   bit e_set, e_foul;

   hit_response dut (
      .clk          (clk),
      .rst          (rst),
      .frame_tick   (frame_tick),
      .inrange      (inrange),
      .spike        (spike),
      .facing_right (facing_right),
      .ball_pos_x   (ball_pos_x),
      .chara_pos_x  (chara_pos_x),
      .touch_clr    (touch_clr),
      .set_vel      (set_vel),
      .new_vx       (new_vx),
      .new_vy       (new_vy),
      .touches      (touches),
      .foul         (foul),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ready = 1; m_in_hit = 0; m_cooling = 0;
      m_left = 0; m_touches = 0; m_vx = 0; m_vy = 0;
      e_set = 0; e_foul = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      int base, dx, q;
      base   = touch_clr ? 0 : m_touches;
      e_set  = 0;
      e_foul = 0;
      if (m_ready && frame_tick && inrange) begin
         m_ready  = 0;
         m_in_hit = 1;
         if (base < 3) begin
            e_set = 1;
            base  = base + 1;
            if (spike) begin
               m_vx = facing_right ? 12 : -12;
               m_vy = 4;
            end else begin
               dx = int'(ball_pos_x) - int'(chara_pos_x);
               q  = (dx >= 0) ? dx / 4 : -((-dx + 3) / 4);
               if (q > 10)  q = 10;
               if (q < -10) q = -10;
               m_vx = q;
               m_vy = -9;
            end
         end else begin
            e_foul = 1;
         end
      end else if (m_in_hit) begin
         m_in_hit  = 0;
         m_cooling = 1;
         m_left    = 20;
      end else if (m_cooling) begin
         if (m_left == 0 && !inrange) begin
            m_cooling = 0;
            m_ready   = 1;
         end else if (frame_tick && m_left > 0) begin
            m_left--;
         end
      end
      m_touches = base;
   endtask

   task automatic compare_all(input string ph);
      chk({ph, "_set_vel"}, int'(set_vel), int'(e_set));
      chk({ph, "_foul"},    int'(foul),    int'(e_foul));
      chk({ph, "_touches"}, int'(touches), m_touches);
      chk({ph, "_busy"},    int'(busy),    int'(m_cooling));
      chk({ph, "_new_vx"},  int'(new_vx),  m_vx);
      chk({ph, "_new_vy"},  int'(new_vy),  m_vy);
   endtask

   task automatic compare_zero(input string ph);
      chk({ph, "_set_vel"}, int'(set_vel), 0);
      chk({ph, "_foul"},    int'(foul),    0);
      chk({ph, "_touches"}, int'(touches), 0);
      chk({ph, "_busy"},    int'(busy),    0);
      chk({ph, "_new_vx"},  int'(new_vx),  0);
      chk({ph, "_new_vy"},  int'(new_vy),  0);
   endtask

   initial begin
      bit did_rst_cool = 0;
      bit did_rst_hit  = 0;
      rst = 1; frame_tick = 0; inrange = 0; spike = 0; facing_right = 0;
      ball_pos_x = '0; chara_pos_x = '0; touch_clr = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_zero("reset");
      rst = 0;

      for (int cyc = 0; cyc < 6000; cyc++) begin
         frame_tick = (cyc % 4 == 0);
         if (frame_tick) begin
            inrange      = ($urandom_range(0, 99) < 55);
            spike        = $urandom_range(0, 2) == 0;
            facing_right = $urandom_range(0, 1) == 1;
            ball_pos_x   = 11'($urandom_range(0, 2046) - 1023);
            chara_pos_x  = 11'($urandom_range(0, 2046) - 1023);
         end
         if (cyc == 0) begin
            inrange = 1; spike = 0; ball_pos_x = 11'sd120; chara_pos_x = 11'sd100;
         end
         // Bias touch_clr onto decisions made with a full touch count.
         if (m_ready && frame_tick && inrange && m_touches == 3)
            touch_clr = $urandom_range(0, 1) == 1;
         else
            touch_clr = $urandom_range(0, 59) == 0;

         model_step();
         @(posedge clk);
         #1;
         compare_all("run");
         if (cyc == 0) begin
            chk("plan_bump_vx", int'(new_vx), 5);
            chk("plan_bump_vy", int'(new_vy), -9);
         end

         if ((!did_rst_cool && cyc > 1500 && m_cooling && m_left == 15) ||
             (!did_rst_hit && cyc > 3500 && m_in_hit)) begin
            if (m_cooling) did_rst_cool = 1; else did_rst_hit = 1;
            rst = 1;
            #1;
            compare_zero("async_rst");
            model_reset();
            @(posedge clk);
            #1;
            rst = 0;
         end
      end

      chk("rst_cool_seen", int'(did_rst_cool), 1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
